// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared constants and types for the pipeline issue controller.
// The PIPE_ISSUE_FUNC_CHK_EN build uses func_legal() to screen undefined ALU ops.
package pipe_ctrl_pkg;
  localparam int REG_W  = 4;
  localparam int ADDR_W = 8;
  localparam int NREGS  = 16;

  typedef enum logic [3:0] {
    FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_SLT,
    FUNC_LD, FUNC_ST, FUNC_SHR, FUNC_SRA, FUNC_SHL
  } func_e;

  localparam logic [3:0] FUNC_MAX = 4'd10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } inflight_t;

  function automatic logic func_legal(input logic [3:0] f);
    return f <= FUNC_MAX;
  endfunction
endpackage

// File: rtl/pipe_issue_ctrl_if.sv
// Requester and issue-side bus of pipe_issue_ctrl.
// The slave modport is the controller's view; master is the requester/pipeline side.
interface pipe_issue_ctrl_if #(parameter int NREQ = 4);
  import pipe_ctrl_pkg::*;
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [REG_W*NREQ-1:0]  req_rs1;
  logic [REG_W*NREQ-1:0]  req_rs2;
  logic [REG_W*NREQ-1:0]  req_rd;
  logic [REG_W*NREQ-1:0]  req_func;
  logic [ADDR_W*NREQ-1:0] req_addr;

  logic                   iss_valid;
  logic [REG_W-1:0]       iss_rs1;
  logic [REG_W-1:0]       iss_rs2;
  logic [REG_W-1:0]       iss_rd;
  logic [REG_W-1:0]       iss_func;
  logic [ADDR_W-1:0]      iss_addr;
  logic [ID_W-1:0]        iss_id;

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_func, req_addr,
    input  req_ready,
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr, iss_id
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_func, req_addr,
    output req_ready,
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr, iss_id
  );
endinterface

// File: rtl/pipe_issue_ctrl_arbiter.sv
// Combinational round-robin pick: first eligible requester at or above ptr, with wrap.
// The pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);
  localparam int IW = $clog2(N);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_grant && eligible[wrap_idx(ptr, k)]) begin
        any_grant                 = 1'b1;
        grant_idx                 = wrap_idx(ptr, k);
        grant[wrap_idx(ptr, k)]   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue scheduler: round-robin among hazard-free requesters, scoreboard holds rd until write-back.
// Optional macro PIPE_ISSUE_FUNC_CHK_EN rejects func > FUNC_MAX and adds the err_func pulse.
module pipe_issue_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_issue_ctrl_if.slave   bus,
  input  logic               hold,
  output logic [NREGS-1:0]   sb_busy,
  output logic [CNT_W-1:0]   stall_cnt
`ifdef PIPE_ISSUE_FUNC_CHK_EN
  ,
  output logic               err_func
`endif
);
  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0]  rr_ptr, ptr_next, grant_idx;
  logic [NREQ-1:0]  eligible, grant;
  logic             any_grant, err_hit;
  logic [REG_W-1:0] rd_g;
  logic [NREGS-1:0] set_mask, clr_mask;
  inflight_t        inflight [WB_LAT];

  function automatic logic [REG_W-1:0] fld(input logic [REG_W*NREQ-1:0] v, input int i);
    return v[REG_W*i +: REG_W];
  endfunction

  function automatic logic [ID_W-1:0] inc_idx(input logic [ID_W-1:0] p);
    return (int'(p) == NREQ-1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = bus.req_valid[i] & ~hold
                  & ~sb_busy[fld(bus.req_rs1, i)]
                  & ~sb_busy[fld(bus.req_rs2, i)]
                  & ~sb_busy[fld(bus.req_rd, i)]
`ifdef PIPE_ISSUE_FUNC_CHK_EN
                  & func_legal(fld(bus.req_func, i))
`endif
                  ;
    end
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign bus.req_ready = rst ? '0 : grant;

`ifdef PIPE_ISSUE_FUNC_CHK_EN
  // An illegal op parked at the pointer would otherwise pin the search forever.
  assign err_hit = bus.req_valid[rr_ptr] & ~hold & ~func_legal(fld(bus.req_func, int'(rr_ptr)));
`else
  assign err_hit = 1'b0;
`endif

  always_comb begin
    rd_g     = fld(bus.req_rd, int'(grant_idx));
    set_mask = any_grant ? (NREGS'(1) << rd_g) : '0;
    clr_mask = inflight[WB_LAT-1].valid ? (NREGS'(1) << inflight[WB_LAT-1].rd) : '0;
    ptr_next = rr_ptr;
    if (any_grant)    ptr_next = inc_idx(grant_idx);
    else if (err_hit) ptr_next = inc_idx(rr_ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      sb_busy      <= '0;
      stall_cnt    <= '0;
      bus.iss_valid <= 1'b0;
      bus.iss_rs1  <= '0;
      bus.iss_rs2  <= '0;
      bus.iss_rd   <= '0;
      bus.iss_func <= '0;
      bus.iss_addr <= '0;
      bus.iss_id   <= '0;
      for (int k = 0; k < WB_LAT; k++) inflight[k] <= '0;
    end else begin
      rr_ptr  <= ptr_next;
      // set after clear so a set wins on a same-bit collision
      sb_busy <= (sb_busy & ~clr_mask) | set_mask;
      inflight[0].valid <= any_grant;
      inflight[0].rd    <= rd_g;
      for (int k = 1; k < WB_LAT; k++) inflight[k] <= inflight[k-1];
      bus.iss_valid <= any_grant;
      if (any_grant) begin
        bus.iss_rs1  <= fld(bus.req_rs1, int'(grant_idx));
        bus.iss_rs2  <= fld(bus.req_rs2, int'(grant_idx));
        bus.iss_rd   <= rd_g;
        bus.iss_func <= fld(bus.req_func, int'(grant_idx));
        bus.iss_addr <= bus.req_addr[ADDR_W*int'(grant_idx) +: ADDR_W];
        bus.iss_id   <= grant_idx;
      end
      if (|bus.req_valid && !hold && !any_grant && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_ISSUE_FUNC_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_func <= 1'b0;
    else     err_func <= err_hit;
  end
`endif
endmodule
